// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// operation encodings and operand-signedness helpers.
package alu_muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   // rs1 is treated as two's complement for these operations
   function automatic logic rs1_signed(input logic [2:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   // rs2 is treated as two's complement for these operations
   function automatic logic rs2_signed(input logic [2:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_muldiv_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module alu_muldiv_cond_neg #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] x,
   input  logic            neg,
   output logic [XLEN-1:0] y
);

   // negate by invert-plus-one when requested, otherwise pass through
   always_comb begin
      if (neg) begin
         y = ~x + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         y = x;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit. One result bit per cycle on operand
// magnitudes; signs are reapplied when the result is captured on entry to DONE.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [2:0]      aluOp,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_r, state_nxt_s;
   logic [2:0]          op_r;
   logic [XLEN-1:0]     a_mag_r, b_mag_r, result_r;
   logic                neg_res_r, neg_rem_r;
   logic [2*XLEN-1:0]   prod_r;      // product, or {unused, dividend/quotient} when dividing
   logic [XLEN-1:0]     rem_r;
   logic [CNT_W-1:0]    cnt_r;

   logic                accept_s, sign_a_s, sign_b_s, fast_s, last_iter_s, ge_s;
   logic [XLEN-1:0]     a_mag_s, b_mag_s, fast_val_s, rem_nxt_s, final_s;
   logic [XLEN:0]       add_s, shift_s;
   logic [2*XLEN-1:0]   prod_nxt_s, fix_in_s, fix_out_s;
   logic                fix_neg_s;

   alu_muldiv_cond_neg #(.XLEN(XLEN)) u_neg_a (.x(operand1), .neg(sign_a_s), .y(a_mag_s));
   alu_muldiv_cond_neg #(.XLEN(XLEN)) u_neg_b (.x(operand2), .neg(sign_b_s), .y(b_mag_s));
   alu_muldiv_cond_neg #(.XLEN(2*XLEN)) u_fix (.x(fix_in_s), .neg(fix_neg_s), .y(fix_out_s));

   // operand signs and the special cases that skip iteration
   always_comb begin
      sign_a_s   = operand1[XLEN-1] & rs1_signed(aluOp);
      sign_b_s   = operand2[XLEN-1] & rs2_signed(aluOp);
      fast_s     = 1'b0;
      fast_val_s = ZERO_X;
      if (aluOp[2] && (operand2 == ZERO_X)) begin
         fast_s     = 1'b1;
         fast_val_s = aluOp[1] ? operand1 : ONES_X;
      end else if (((aluOp == OP_DIV) || (aluOp == OP_REM)) &&
                   (operand1 == MOST_NEG) && (operand2 == ONES_X)) begin
         fast_s     = 1'b1;
         fast_val_s = aluOp[1] ? ZERO_X : operand1;
      end else begin
         fast_s     = 1'b0;
         fast_val_s = ZERO_X;
      end
   end

   // one shift-add or restoring-divide step, plus sign fix-up of the step's outcome
   always_comb begin
      add_s       = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
      shift_s     = {rem_r, prod_r[XLEN-1]};
      ge_s        = (shift_s >= {1'b0, b_mag_r});
      prod_nxt_s  = prod_r;
      rem_nxt_s   = rem_r;
      if (state_r == ST_MUL) begin
         prod_nxt_s = {add_s, prod_r[XLEN-1:1]};
      end else if (state_r == ST_DIV) begin
         prod_nxt_s = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-2:0], ge_s};
         rem_nxt_s  = ge_s ? XLEN'(shift_s - {1'b0, b_mag_r}) : shift_s[XLEN-1:0];
      end else begin
         prod_nxt_s = prod_r;
         rem_nxt_s  = rem_r;
      end
      if (state_r == ST_DIV) begin
         fix_in_s  = {ZERO_X, (op_r[1] ? rem_nxt_s : prod_nxt_s[XLEN-1:0])};
         fix_neg_s = op_r[1] ? neg_rem_r : neg_res_r;
      end else begin
         fix_in_s  = prod_nxt_s;
         fix_neg_s = neg_res_r;
      end
      if ((state_r == ST_MUL) && (op_r != OP_MUL)) begin
         final_s = fix_out_s[2*XLEN-1:XLEN];
      end else begin
         final_s = fix_out_s[XLEN-1:0];
      end
      last_iter_s = (cnt_r == CNT_ONE);
      zero        = (result_r == ZERO_X);
      result      = result_r;
   end

   // next-state and handshake outputs
   always_comb begin
      in_ready    = (state_r == ST_IDLE) && !rst;
      out_valid   = (state_r == ST_DONE);
      accept_s    = in_valid && in_ready;
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = fast_s ? ST_DONE : (aluOp[2] ? ST_DIV : ST_MUL);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (last_iter_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // operand capture, iteration datapath and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= 3'b000;
         a_mag_r   <= ZERO_X;
         b_mag_r   <= ZERO_X;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         prod_r    <= {(2*XLEN){1'b0}};
         rem_r     <= ZERO_X;
         cnt_r     <= {CNT_W{1'b0}};
         result_r  <= ZERO_X;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r      <= aluOp;
                  a_mag_r   <= a_mag_s;
                  b_mag_r   <= b_mag_s;
                  neg_res_r <= sign_a_s ^ sign_b_s;
                  neg_rem_r <= sign_a_s;
                  prod_r    <= {ZERO_X, (aluOp[2] ? a_mag_s : b_mag_s)};
                  rem_r     <= ZERO_X;
                  cnt_r     <= CNT_LOAD;
                  if (fast_s) begin
                     result_r <= fast_val_s;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               prod_r <= prod_nxt_s;
               rem_r  <= rem_nxt_s;
               cnt_r  <= cnt_r - CNT_ONE;
               if (last_iter_s) begin
                  result_r <= final_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_muldiv;

   localparam logic [2:0] T_MUL = 3'b000, T_MULH = 3'b001, T_MULHSU = 3'b010, T_MULHU = 3'b011;
   localparam logic [2:0] T_DIV = 3'b100, T_DIVU = 3'b101, T_REM = 3'b110, T_REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, zero;
   logic [31:0] operand1, operand2, result;
   logic [2:0]  aluOp;

   typedef struct {
      logic [31:0] res;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   tests = 0, fails = 0, cyc = 0, acc_cyc = 0, hs_cyc = 0;
   bit   lat_pending = 1'b0;

   alu_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand1(operand1), .operand2(operand2), .aluOp(aluOp),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // monitor: latency of each op and result/zero at each output handshake
   always @(negedge clk) begin
      if (in_valid && in_ready) begin
         acc_cyc     = cyc;
         lat_pending = 1'b1;
      end
      if (out_valid && lat_pending) begin
         lat_pending = 1'b0;
         if (sb_q.size() > 0) check({sb_q[0].name, " latency"}, 32'(cyc - acc_cyc), 32'(sb_q[0].lat));
      end
      if (out_valid && out_ready) begin
         hs_cyc = cyc;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got result 0x%08h, required no output", result);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, " result"}, result, mon_e.res);
            check({mon_e.name, " zero"}, {31'b0, zero}, {31'b0, (mon_e.res == 32'd0)});
         end
      end
   end

   task automatic wait_accept();
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready && in_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
      end
   endtask

   task automatic wait_idle();
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending results, required 0", sb_q.size());
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string name);
      sb_q.push_back('{exp_res, lat, name});
      @(posedge clk); #1;
      aluOp    = op;
      operand1 = a;
      operand2 = b;
      in_valid = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of run, required finish within 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ov_seen;
      int a_cyc;
      bit seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      operand1 = 32'd0; operand2 = 32'd0; aluOp = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset zero", {31'b0, zero}, 32'd1);
      check("reset in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready after reset", {31'b0, in_ready}, 32'd1);

      // multiply
      send(T_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33, "MUL 7 x -3");
      send(T_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33, "MULH min x min");
      send(T_MULHU,  32'h80000000,   32'h80000000, 32'h40000000, 33, "MULHU 2^31 x 2^31");
      send(T_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, "MULHSU -1 x max");
      send(T_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU max x max");
      send(T_MULH,   32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33, "MULH -1 x 2");
      send(T_MUL,    32'h12345678,   32'd0,        32'd0,        33, "MUL x 0");
      // divide
      send(T_DIVU,   32'd100,        32'd7,        32'd14,       33, "DIVU 100/7");
      send(T_REMU,   32'd100,        32'd7,        32'd2,        33, "REMU 100/7");
      send(T_DIV,    32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 33, "DIV -100/7");
      send(T_REM,    32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 33, "REM -100/7");
      send(T_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33, "DIV 7/-2");
      send(T_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33, "REM 7/-2");
      send(T_DIVU,   32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 33, "DIVU max/1");
      // fast paths
      send(T_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1,  "DIV 5/0");
      send(T_REM,    32'd5,          32'd0,        32'd5,        1,  "REM 5/0");
      send(T_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1,  "DIVU 5/0");
      send(T_REMU,   32'd9,          32'd0,        32'd9,        1,  "REMU 9/0");
      send(T_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  "DIV min/-1");
      send(T_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1,  "REM min/-1");

      // back-pressure with a second op held on the input
      out_ready = 1'b0;
      sb_q.push_back('{32'd14, 33, "bp DIVU 100/7"});
      @(posedge clk); #1;
      aluOp = T_DIVU; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      sb_q.push_back('{32'hFFFFFFEB, 33, "bp MUL 7 x -3"});
      aluOp = T_MUL; operand1 = 32'd7; operand2 = 32'hFFFFFFFD;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("bp out_valid rises", {31'b0, seen}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("bp result stable", result, 32'd14);
         check("bp in_ready low", {31'b0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_accept();
      a_cyc = cyc;
      check("bp second accept cycle", 32'(a_cyc), 32'(hs_cyc + 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();

      // reset in the middle of a divide drops it
      @(posedge clk); #1;
      aluOp = T_DIVU; operand1 = 32'd1000; operand2 = 32'd3; in_valid = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("in_ready during rst", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post-rst in_ready", {31'b0, in_ready}, 32'd1);
      check("post-rst result", result, 32'd0);
      check("post-rst zero", {31'b0, zero}, 32'd1);
      ov_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check("dropped op out_valid", 32'(ov_seen), 32'd0);
      send(T_MULHU, 32'd3, 32'd5, 32'd0, 33, "MULHU 3 x 5 after rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
